// File: rtl/ofs_fim_axis_fifo_pkg.sv
// ofs_fim_axis_fifo_pkg: shared widths, beat/mode types and almfull helper for the packet FIFO
package ofs_fim_axis_fifo_pkg;
    localparam int AXIS_TDATA_WIDTH = 512;
    localparam int AXIS_TKEEP_WIDTH = AXIS_TDATA_WIDTH / 8;
    localparam int AXIS_TUSER_WIDTH = 10;

    typedef struct packed {
        logic [AXIS_TDATA_WIDTH-1:0] tdata;
        logic [AXIS_TKEEP_WIDTH-1:0] tkeep;
        logic [AXIS_TUSER_WIDTH-1:0] tuser_vendor;
        logic                        tlast;
    } t_axis_beat;

    typedef enum logic {CUT_THROUGH = 1'b0, STORE_FWD = 1'b1} t_fifo_mode;

    function automatic int calc_almfull_level(input int depth_log2, input int thr);
        return (1 << depth_log2) - thr;
    endfunction
endpackage

// File: rtl/ofs_fim_axis_pkt_fifo_if.sv
// ofs_fim_axis_pkt_fifo_if: AXI-S handshake and payload bundle
//   master: drives tvalid/tdata/tkeep/tuser_vendor/tlast, receives tready
//   slave : receives tvalid/payload, drives tready
interface ofs_fim_axis_pkt_fifo_if
    import ofs_fim_axis_fifo_pkg::*;
#(
    parameter int TDATA_WIDTH = AXIS_TDATA_WIDTH,
    parameter int TUSER_WIDTH = AXIS_TUSER_WIDTH
);
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic [TUSER_WIDTH-1:0]   tuser_vendor;
    modport master (output tvalid, tdata, tkeep, tuser_vendor, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tuser_vendor, tlast, output tready);
endinterface

// File: rtl/ofs_fim_sc_ram.sv
// ofs_fim_sc_ram: simple dual-port RAM with one-cycle registered read
//   clk          : clock
//   we/waddr/wdata: write port
//   raddr/rdata  : read port, rdata valid the cycle after raddr
module ofs_fim_sc_ram #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [1 << DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/ofs_fim_axis_pkt_fifo.sv
// ofs_fim_axis_pkt_fifo: single-clock AXI-S FIFO with cut-through / store-and-forward modes
//   clk, rst   : clock, synchronous active-high reset
//   sf_mode    : 1 = store-and-forward, 0 = cut-through, taken only while empty
//   s / m      : AXI-S sink (slave modport) and source (master modport)
//   usedw      : entries occupied, output register included
//   pkt_cnt    : complete packets held
//   ovf_sticky : store-and-forward forced release seen since reset
module ofs_fim_axis_pkt_fifo
    import ofs_fim_axis_fifo_pkg::*;
#(
    parameter int TDATA_WIDTH       = AXIS_TDATA_WIDTH,
    parameter int TUSER_WIDTH       = AXIS_TUSER_WIDTH,
    parameter int DEPTH_LOG2        = 6,
    parameter int ALMFULL_THRESHOLD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sf_mode,
    ofs_fim_axis_pkt_fifo_if.slave  s,
    ofs_fim_axis_pkt_fifo_if.master m,
    output logic [DEPTH_LOG2:0]   usedw,
    output logic [DEPTH_LOG2:0]   pkt_cnt,
    output logic                  ovf_sticky
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] ALM_LVL =
        (DEPTH_LOG2+1)'(calc_almfull_level(DEPTH_LOG2, ALMFULL_THRESHOLD));

    if (ALMFULL_THRESHOLD < 1 || ALMFULL_THRESHOLD > DEPTH - 1 || TDATA_WIDTH % 8 != 0) begin : g_bad_cfg
        $fatal(1, "ofs_fim_axis_pkt_fifo: illegal ALMFULL_THRESHOLD or TDATA_WIDTH");
    end

    typedef struct packed {
        logic [TDATA_WIDTH-1:0]   tdata;
        logic [TDATA_WIDTH/8-1:0] tkeep;
        logic [TUSER_WIDTH-1:0]   tuser_vendor;
        logic                     tlast;
    } t_beat;

    t_beat                 s_beat, oreg, head, ram_q, fwd_data;
    t_fifo_mode            sf_q;
    logic                  ov, fwd_sel, almfull, force_ct, force_set;
    logic                  wr, rd, load, gate;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [DEPTH_LOG2:0]   usedw_nxt, rc;

    assign s_beat    = {s.tdata, s.tkeep, s.tuser_vendor, s.tlast};
    assign s.tready  = ~almfull;
    assign wr        = s.tvalid && s.tready;
    assign gate      = sf_q == CUT_THROUGH || pkt_cnt != 0 || force_ct;
    assign m.tvalid  = ov && gate;
    assign rd        = m.tvalid && m.tready;
    // rc: entries still in RAM behind the output register
    assign rc        = usedw - (DEPTH_LOG2+1)'(ov);
    // Every beat is written to RAM; when nothing is queued behind the output
    // register, the incoming beat is taken straight into it instead.
    assign load      = (!ov || rd) && (rc != 0 || wr);
    assign rd_ptr_nxt = rd_ptr + DEPTH_LOG2'(load);
    // RAM read is registered from rd_ptr_nxt; a write to that same slot is
    // forwarded since the RAM returns the old word.
    assign head      = rc != 0 ? (fwd_sel ? fwd_data : ram_q) : s_beat;
    assign usedw_nxt = usedw + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(rd);
    assign force_set = sf_q == STORE_FWD && pkt_cnt == 0 && almfull;

    assign m.tdata        = oreg.tdata;
    assign m.tkeep        = oreg.tkeep;
    assign m.tuser_vendor = oreg.tuser_vendor;
    assign m.tlast        = oreg.tlast;

    ofs_fim_sc_ram #(.WIDTH($bits(t_beat)), .DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk(clk), .we(wr), .waddr(wr_ptr), .wdata(s_beat), .raddr(rd_ptr_nxt), .rdata(ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            usedw      <= '0;
            pkt_cnt    <= '0;
            ov         <= 1'b0;
            oreg       <= '0;
            fwd_sel    <= 1'b0;
            fwd_data   <= '0;
            almfull    <= 1'b1;
            force_ct   <= 1'b0;
            ovf_sticky <= 1'b0;
            sf_q       <= CUT_THROUGH;
        end else begin
            wr_ptr   <= wr_ptr + DEPTH_LOG2'(wr);
            rd_ptr   <= rd_ptr_nxt;
            usedw    <= usedw_nxt;
            pkt_cnt  <= pkt_cnt + (DEPTH_LOG2+1)'(wr && s.tlast) - (DEPTH_LOG2+1)'(rd && m.tlast);
            ov       <= load || (ov && !rd);
            fwd_sel  <= wr && wr_ptr == rd_ptr_nxt;
            fwd_data <= s_beat;
            almfull  <= usedw_nxt >= ALM_LVL;
            if (load) oreg <= head;
            if (force_set) begin
                force_ct   <= 1'b1;
                ovf_sticky <= 1'b1;
            end else if (rd && m.tlast) begin
                force_ct <= 1'b0;
            end
            if (usedw == 0 && !wr) sf_q <= sf_mode ? STORE_FWD : CUT_THROUGH;
        end
    end
endmodule

// File: tb/tb_ofs_fim_axis_pkt_fifo.sv
// tb_ofs_fim_axis_pkt_fifo: directed and random checks of the packet FIFO against a beat queue model
module tb_ofs_fim_axis_pkt_fifo;
    localparam int TDW = 512;
    localparam int TUW = 10;
    localparam int DL2 = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           sf_mode = 1'b0;
    logic [DL2:0]   usedw, pkt_cnt;
    logic           ovf_sticky;
    int             n_chk = 0;
    int             n_pass = 0;
    logic [586:0]   q [$];

    ofs_fim_axis_pkt_fifo_if #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)) s_if ();
    ofs_fim_axis_pkt_fifo_if #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)) m_if ();

    ofs_fim_axis_pkt_fifo #(
        .TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW), .DEPTH_LOG2(DL2), .ALMFULL_THRESHOLD(2)
    ) dut (
        .clk(clk), .rst(rst), .sf_mode(sf_mode), .s(s_if), .m(m_if),
        .usedw(usedw), .pkt_cnt(pkt_cnt), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int id, input logic last);
        s_if.tvalid       = 1'b1;
        s_if.tdata        = {16{id}};
        s_if.tkeep        = {2{~id}};
        s_if.tuser_vendor = 10'(id);
        s_if.tlast        = last;
    endtask

    task automatic send(input int base, input int n, input logic last);
        int  i = 0;
        bit  took;
        for (int c = 0; c < 2000 && i < n; c++) begin
            drive_beat(base + i, last && i == n - 1);
            took = s_if.tready;
            tick();
            if (took) i++;
        end
        s_if.tvalid = 1'b0;
        check("send_cnt", i, n);
    endtask

    task automatic drain();
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        for (int c = 0; c < 1000 && (usedw != 0 || m_if.tvalid); c++) tick();
        check("drain_usedw", usedw, 0);
    endtask

    // Model: every accepted beat queued, every delivered beat popped and compared;
    // occupancy and packet count follow directly from the queue.
    always @(negedge clk) begin : mon
        int nl;
        if (rst) q.delete();
        else begin
            nl = 0;
            foreach (q[i]) nl += int'(q[i][0]);
            check("usedw_model", usedw, q.size());
            check("pkt_cnt_model", pkt_cnt, nl);
            if (m_if.tvalid && m_if.tready) begin
                if (q.size() == 0) check("pop_empty", 1, 0);
                else check("beat", {m_if.tdata, m_if.tkeep, m_if.tuser_vendor, m_if.tlast}, q.pop_front());
            end
            if (s_if.tvalid && s_if.tready)
                q.push_back({s_if.tdata, s_if.tkeep, s_if.tuser_vendor, s_if.tlast});
        end
    end

    initial begin
        int  acc, sent, left;
        bit  took, seen;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser_vendor = '0; s_if.tlast = 1'b0;
        m_if.tready = 1'b0;
        repeat (3) tick();
        check("rst_s_tready", s_if.tready, 0);
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_usedw", usedw, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_ovf", ovf_sticky, 0);
        check("rst_m_tdata", m_if.tdata, 0);
        rst = 1'b0;
        check("tready_late", s_if.tready, 0);
        tick();
        check("tready_up", s_if.tready, 1);

        // cut-through, 10 beats back-to-back
        m_if.tready = 1'b1;
        check("ct_idle", m_if.tvalid, 0);
        for (int i = 0; i < 10; i++) begin
            drive_beat(i, i == 9);
            tick();
            check("ct_vld", m_if.tvalid, 1);
        end
        s_if.tvalid = 1'b0;
        tick();
        check("ct_usedw0", usedw, 0);
        check("ct_vld0", m_if.tvalid, 0);

        // store-and-forward, 4-beat packet
        sf_mode = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_beat(100 + i, i == 3);
            tick();
            if (i < 3) check("sf_hold", m_if.tvalid, 0);
        end
        s_if.tvalid = 1'b0;
        check("sf_pkt1", pkt_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            check("sf_contig", m_if.tvalid, 1);
            check("sf_tlast", m_if.tlast, i == 3);
            tick();
        end
        check("sf_done", m_if.tvalid, 0);
        check("sf_pkt0", pkt_cnt, 0);

        // fill with output stalled
        sf_mode = 1'b0;
        m_if.tready = 1'b0;
        tick();
        acc = 0;
        for (int c = 0; c < 70; c++) begin
            drive_beat(200 + acc, 1'b0);
            if (s_if.tready) acc++;
            tick();
        end
        s_if.tvalid = 1'b0;
        check("fill_acc", acc, 62);
        check("fill_usedw", usedw, 62);
        check("fill_tready", s_if.tready, 0);
        drain();

        // oversized store-and-forward packet
        sf_mode = 1'b1;
        m_if.tready = 1'b1;
        tick();
        check("ovf_pre", ovf_sticky, 0);
        sent = 0;
        seen = 1'b0;
        for (int c = 0; c < 2000 && sent < 80; c++) begin
            if (!seen && ovf_sticky) begin
                seen = 1'b1;
                check("ovf_usedw", usedw, 62);
            end
            drive_beat(300 + sent, sent == 79);
            took = s_if.tready;
            tick();
            if (took) sent++;
        end
        s_if.tvalid = 1'b0;
        check("ovf_sent", sent, 80);
        check("ovf_seen", seen, 1);
        drain();
        check("ovf_sticky", ovf_sticky, 1);
        drive_beat(400, 1'b0);
        tick();
        check("fct_cleared", m_if.tvalid, 0);
        drive_beat(401, 1'b1);
        tick();
        s_if.tvalid = 1'b0;
        check("fct_release", m_if.tvalid, 1);
        drain();

        // random valid/ready, mixed packet lengths, random mode requests
        sent = 0;
        left = 0;
        for (int c = 0; c < 40000 && (sent < 3000 || left != 0); c++) begin
            if (!s_if.tvalid && $urandom_range(1, 0) == 1 && (sent < 3000 || left != 0)) begin
                if (left == 0) left = $urandom_range(20, 1);
                drive_beat(1000 + sent, left == 1);
            end
            m_if.tready = $urandom_range(9, 0) < 3;
            sf_mode = 1'($urandom_range(1, 0));
            took = s_if.tvalid && s_if.tready;
            tick();
            if (took) begin
                sent++;
                left--;
                s_if.tvalid = 1'b0;
            end
        end
        check("rnd_left", left, 0);
        drain();

        // reset mid-packet
        sf_mode = 1'b1;
        m_if.tready = 1'b0;
        tick();
        send(500, 17, 1'b0);
        check("mid_usedw", usedw, 17);
        rst = 1'b1;
        tick();
        check("mrst_usedw", usedw, 0);
        check("mrst_pkt_cnt", pkt_cnt, 0);
        check("mrst_m_tvalid", m_if.tvalid, 0);
        check("mrst_s_tready", s_if.tready, 0);
        check("mrst_m_tdata", m_if.tdata, 0);
        rst = 1'b0;
        tick();
        tick();
        m_if.tready = 1'b1;
        send(600, 3, 1'b1);
        drain();
        check("mrst_ovf", ovf_sticky, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
